// File: rtl/dds_pkg.sv
// Shared DDS definitions: default tuning-word width and the sweep FSM state type.
package dds_pkg;

  // Phase-accumulator width used by the DDS generator and its controllers.
  localparam int DDS_PHASE_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter. A load of 0 is treated as 1. The counter parks at 1
// once it runs out, so expire stays high until the next load.
module dds_dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] value,
  output logic                   expire
);

  localparam logic [DWELL_WIDTH-1:0] ONE = DWELL_WIDTH'(1);

  logic [DWELL_WIDTH-1:0] cnt;

  // Count down one per cycle towards 1; a load restarts the dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == '0) ? ONE : value;
    end else if (cnt > ONE) begin
      cnt <= cnt - ONE;
    end
  end

  assign expire = (cnt == ONE);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller driving the DDS delta_phase input.
// Build option: define DDS_SWEEP_CONTINUOUS_EN to honour `mode` and build the DOWN
// (triangle) path; otherwise every sweep is a single up-sweep ending in `done`.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [PHASE_WIDTH-1:0] f_start,
  input  logic [PHASE_WIDTH-1:0] f_stop,
  input  logic [PHASE_WIDTH-1:0] f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [PHASE_WIDTH-1:0] delta_phase,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  sweep_state_t state, state_nxt;

  logic [PHASE_WIDTH-1:0] cfg_stop;
  logic [PHASE_WIDTH-1:0] cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [DWELL_WIDTH-1:0] tmr_value;
  logic                   cfg_valid;
  logic                   start_ok;
  logic                   start_bad;
  logic                   tmr_load;
  logic                   expire;
  logic                   at_stop;
  logic [PHASE_WIDTH:0]   up_sum;
  logic [PHASE_WIDTH-1:0] up_next;

`ifdef DDS_SWEEP_CONTINUOUS_EN
  logic                   cfg_mode;
  logic [PHASE_WIDTH-1:0] cfg_start;
  logic [PHASE_WIDTH:0]   dn_diff;
  logic [PHASE_WIDTH-1:0] dn_next;
  logic                   at_start;
`else
  // Port kept for interface stability; single sweeps only in this build.
  logic mode_unused;
  assign mode_unused = mode;
`endif

  // Start qualification is done on the live inputs; abort always takes priority.
  assign cfg_valid = (f_step != '0) && (f_start <= f_stop);
  assign start_ok  = (state == S_IDLE) && start && !abort && cfg_valid;
  assign start_bad = (state == S_IDLE) && start && !abort && !cfg_valid;

  // Up-step at one extra bit so a step past the top of the range clamps instead of wrapping.
  assign up_sum  = {1'b0, delta_phase} + {1'b0, cfg_step};
  assign up_next = (up_sum > {1'b0, cfg_stop}) ? cfg_stop : up_sum[PHASE_WIDTH-1:0];
  assign at_stop = (delta_phase == cfg_stop);

`ifdef DDS_SWEEP_CONTINUOUS_EN
  // Down-step at one extra bit; the borrow bit flags underflow, which clamps to f_start.
  assign dn_diff  = {1'b0, delta_phase} - {1'b0, cfg_step};
  assign dn_next  = (dn_diff[PHASE_WIDTH] || (dn_diff[PHASE_WIDTH-1:0] < cfg_start))
                    ? cfg_start : dn_diff[PHASE_WIDTH-1:0];
  assign at_start = (delta_phase == cfg_start);
`endif

  // The first dwell comes from the live input, later ones from the latched copy.
  assign tmr_value = busy ? cfg_dwell : dwell;
  assign tmr_load  = start_ok || (busy && expire);

  dds_dwell_timer #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (expire)
  );

  // Latch the sweep configuration on an accepted start.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      cfg_stop  <= f_stop;
      cfg_step  <= f_step;
      cfg_dwell <= dwell;
`ifdef DDS_SWEEP_CONTINUOUS_EN
      cfg_start <= f_start;
      cfg_mode  <= mode;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; turnarounds happen only on dwell expiry at an endpoint.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_ok) state_nxt = S_UP;
        S_UP: begin
          if (expire && at_stop) begin
`ifdef DDS_SWEEP_CONTINUOUS_EN
            state_nxt = cfg_mode ? S_DOWN : S_IDLE;
`else
            state_nxt = S_IDLE;
`endif
          end
        end
`ifdef DDS_SWEEP_CONTINUOUS_EN
        S_DOWN: if (expire && at_start) state_nxt = S_UP;
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state == S_UP) || (state == S_DOWN);
  end

  // Tuning-word register: load on start, clamped step on dwell expiry, zero on abort.
  // At a turnaround the first step in the new direction is taken immediately so the
  // endpoint word is not held twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_phase <= '0;
    end else if (abort) begin
      delta_phase <= '0;
    end else if (start_ok) begin
      delta_phase <= f_start;
    end else if (expire) begin
      case (state)
        S_UP: begin
          if (!at_stop) begin
            delta_phase <= up_next;
          end
`ifdef DDS_SWEEP_CONTINUOUS_EN
          else if (cfg_mode) begin
            delta_phase <= dn_next;
          end
`endif
        end
`ifdef DDS_SWEEP_CONTINUOUS_EN
        S_DOWN: delta_phase <= at_start ? up_next : dn_next;
`endif
        default: ;
      endcase
    end
  end

  // One-cycle status pulses: done on a normal single-sweep finish, err on a rejected start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= !abort && (state == S_UP) && (state_nxt == S_IDLE);
      err  <= start_bad;
    end
  end

endmodule
